// File: rtl/prbs_checker_if.sv
// Stream/status bundle between a PRBS source (master) and the PRBS checker (slave).
interface prbs_checker_if #(
  parameter int CNT_W = 16
);
  logic             bit_in;
  logic             bit_valid;
  logic             clear_count;
  logic             locked;
  logic             err_pulse;
  logic             sync_loss;
  logic [CNT_W-1:0] err_count;

  modport master (
    output bit_in, bit_valid, clear_count,
    input  locked, err_pulse, sync_loss, err_count
  );

  modport slave (
    input  bit_in, bit_valid, clear_count,
    output locked, err_pulse, sync_loss, err_count
  );
endinterface

// File: rtl/prbs_checker.sv
// Self-synchronising checker for the x^32+x^30+x^26+x^25 Fibonacci PRBS: seeds from the
// stream, verifies, then free-runs a local reference and counts bit errors per window.
module prbs_checker #(
  parameter int LOCK_COUNT  = 64,
  parameter int WINDOW      = 256,
  parameter int LOSS_THRESH = 16,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  prbs_checker_if.slave        bus
);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int WBIT_W  = $clog2(WINDOW + 1);
  localparam int WERR_W  = $clog2(LOSS_THRESH + 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [WBIT_W-1:0]  WBIT_LAST  = WBIT_W'(WINDOW - 1);
  localparam logic [WERR_W-1:0]  WERR_LIM   = WERR_W'(LOSS_THRESH);

  typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_e;

  state_e              state_q, state_d;
  logic [31:0]         h_q, h_d;
  logic [4:0]          fill_q, fill_d;
  logic [MATCH_W-1:0]  match_q, match_d;
  logic [WBIT_W-1:0]   wbit_q, wbit_d;
  logic [WERR_W-1:0]   werr_q, werr_d;
  logic [CNT_W-1:0]    err_count_q, err_count_d;
  logic                err_pulse_q, err_pulse_d;
  logic                sync_loss_q, sync_loss_d;
  logic                pred;
  logic                mism;
  logic                err_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    pred        = h_q[31] ^ h_q[29] ^ h_q[25] ^ h_q[24];
    mism        = bus.bit_in ^ pred;
    state_d     = state_q;
    h_d         = h_q;
    fill_d      = fill_q;
    match_d     = match_q;
    wbit_d      = wbit_q;
    werr_d      = werr_q;
    err_hit     = 1'b0;
    sync_loss_d = 1'b0;

    if (bus.bit_valid) begin
      unique case (state_q)
        SEED: begin
          h_d = {h_q[30:0], bus.bit_in};
          if (fill_q == 5'd31) begin
            fill_d = '0;
            // An all-zero history is a fixed point of the recurrence, so never verify it.
            if (h_d != '0) begin
              state_d = VERIFY;
              match_d = '0;
            end
          end else begin
            fill_d = fill_q + 5'd1;
          end
        end
        VERIFY: begin
          h_d = {h_q[30:0], bus.bit_in};
          if (mism) begin
            state_d = SEED;
            fill_d  = '0;
          end else if (match_q == MATCH_LAST) begin
            state_d = LOCKED;
            wbit_d  = '0;
            werr_d  = '0;
          end else begin
            match_d = match_q + MATCH_W'(1);
          end
        end
        LOCKED: begin
          // Feed back the prediction, not the received bit, so a flip costs one error only.
          h_d     = {h_q[30:0], pred};
          err_hit = mism;
          werr_d  = werr_q + WERR_W'(mism);
          wbit_d  = wbit_q + WBIT_W'(1);
          if (werr_d == WERR_LIM) begin
            state_d     = SEED;
            fill_d      = '0;
            sync_loss_d = 1'b1;
            wbit_d      = '0;
            werr_d      = '0;
          end else if (wbit_q == WBIT_LAST) begin
            wbit_d = '0;
            werr_d = '0;
          end
        end
        default: state_d = SEED;
      endcase
    end

    err_pulse_d = err_hit;
    if (bus.clear_count) begin
      err_count_d = {{(CNT_W-1){1'b0}}, err_hit};
    end else if (err_hit) begin
      err_count_d = sat_inc(err_count_q);
    end else begin
      err_count_d = err_count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SEED;
      h_q         <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      wbit_q      <= '0;
      werr_q      <= '0;
      err_count_q <= '0;
      err_pulse_q <= 1'b0;
      sync_loss_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      wbit_q      <= wbit_d;
      werr_q      <= werr_d;
      err_count_q <= err_count_d;
      err_pulse_q <= err_pulse_d;
      sync_loss_q <= sync_loss_d;
    end
  end

  assign bus.locked    = (state_q == LOCKED);
  assign bus.err_pulse = err_pulse_q;
  assign bus.sync_loss = sync_loss_q;
  assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: a queue-based behavioural model predicts every cycle's
// outputs while a separate monitor compares them; directed phases add milestone checks.
module tb_prbs_checker;
  localparam int LOCK_COUNT  = 64;
  localparam int WINDOW      = 256;
  localparam int LOSS_THRESH = 16;
  localparam int CNT_W       = 16;
  localparam int LOCK_LAT    = 32 + LOCK_COUNT;
  localparam int MAXC        = (1 << CNT_W) - 1;
  localparam int M_SEED = 0, M_VERIFY = 1, M_LOCKED = 2;

  typedef struct packed {
    logic             locked;
    logic             pulse;
    logic             loss;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prbs_checker_if #(.CNT_W(CNT_W)) bus ();

  prbs_checker #(
    .LOCK_COUNT(LOCK_COUNT), .WINDOW(WINDOW), .LOSS_THRESH(LOSS_THRESH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  // Behavioural reference state
  int   mode, nfill, nmatch, wbits, werr, ecnt;
  bit   hist[$];          // hist[0] = oldest of the last 32 accepted bits
  logic [31:0] g = 32'h1; // generator state, seed 1

  function automatic bit gen_bit();
    bit nb;
    nb = g[31] ^ g[29] ^ g[25] ^ g[24];
    g  = {g[30:0], nb};
    return nb;
  endfunction

  task automatic push_hist(input bit x);
    hist.push_back(x);
    void'(hist.pop_front());
  endtask

  task automatic model_step(input bit rn, input bit v, input bit b, input bit clr);
    exp_t e;
    bit   p, counted, nz;
    e = '0;
    if (!rn) begin
      mode = M_SEED; nfill = 0; nmatch = 0; wbits = 0; werr = 0; ecnt = 0;
      hist.delete();
      repeat (32) hist.push_back(1'b0);
      sb.push_back(e);
      return;
    end
    counted = 1'b0;
    if (v) begin
      p = hist[0] ^ hist[2] ^ hist[6] ^ hist[7];
      case (mode)
        M_SEED: begin
          push_hist(b);
          nfill++;
          if (nfill == 32) begin
            nfill = 0;
            nz = 1'b0;
            foreach (hist[i]) nz |= hist[i];
            if (nz) begin mode = M_VERIFY; nmatch = 0; end
          end
        end
        M_VERIFY: begin
          push_hist(b);
          if (b == p) begin
            nmatch++;
            if (nmatch == LOCK_COUNT) begin mode = M_LOCKED; wbits = 0; werr = 0; end
          end else begin
            mode = M_SEED; nfill = 0;
          end
        end
        default: begin
          push_hist(p);
          wbits++;
          if (b != p) begin counted = 1'b1; werr++; end
          if (werr == LOSS_THRESH) begin
            mode = M_SEED; nfill = 0; e.loss = 1'b1; wbits = 0; werr = 0;
          end else if (wbits == WINDOW) begin
            wbits = 0; werr = 0;
          end
        end
      endcase
    end
    if (clr) ecnt = counted ? 1 : 0;
    else if (counted && ecnt < MAXC) ecnt++;
    e.pulse  = counted;
    e.locked = (mode == M_LOCKED);
    e.cnt    = CNT_W'(ecnt);
    sb.push_back(e);
  endtask

  task automatic drive_raw(input bit v, input bit b, input bit clr);
    @(negedge clk);
    rst_n           = 1'b1;
    bus.bit_valid   = v;
    bus.bit_in      = b;
    bus.clear_count = clr;
    model_step(1'b1, v, b, clr);
  endtask

  task automatic drive(input bit v, input bit flip, input bit clr);
    bit b;
    if (v) b = gen_bit() ^ flip;
    else   b = 1'($urandom_range(0, 1));
    drive_raw(v, b, clr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n           = 1'b0;
    bus.bit_valid   = 1'b1;
    bus.bit_in      = 1'($urandom_range(0, 1));
    bus.clear_count = 1'($urandom_range(0, 1));
    model_step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, want);
    end
  endtask

  // Monitor: compares the DUT against the oldest prediction after every active edge.
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = {bus.locked, bus.err_pulse, bus.sync_loss, bus.err_count};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL scoreboard @%0t: got locked=%b pulse=%b loss=%b cnt=%0d, expected locked=%b pulse=%b loss=%b cnt=%0d",
                   $time, a.locked, a.pulse, a.loss, a.cnt, e.locked, e.pulse, e.loss, e.cnt);
        end
      end
    end
  end

  task automatic lock_check(input string nm);
    repeat (LOCK_LAT - 1) drive(1'b1, 1'b0, 1'b0);
    settle();
    chk({nm, "_prelock"}, 32'(bus.locked), 0);
    drive(1'b1, 1'b0, 1'b0);
    settle();
    chk({nm, "_lock"}, 32'(bus.locked), 1);
  endtask

  initial begin
    int rate;
    bus.bit_in = 1'b0; bus.bit_valid = 1'b0; bus.clear_count = 1'b0;

    // Reset values and lock latency from reset
    do_reset();
    settle();
    chk("rst_locked", 32'(bus.locked), 0);
    chk("rst_count", 32'(bus.err_count), 0);
    lock_check("first");
    repeat (10000) drive(1'b1, 1'b0, 1'b0);
    settle();
    chk("clean_count", 32'(bus.err_count), 0);
    chk("clean_locked", 32'(bus.locked), 1);

    // Single flipped bit, then clear
    drive(1'b1, 1'b1, 1'b0);
    settle();
    chk("single_pulse", 32'(bus.err_pulse), 1);
    chk("single_count", 32'(bus.err_count), 1);
    chk("single_locked", 32'(bus.locked), 1);
    repeat (5) drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    settle();
    chk("clear_count", 32'(bus.err_count), 0);

    // LOSS_THRESH errors inside one window
    while (wbits != 0) drive(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= LOSS_THRESH; k++) begin
      drive(1'b1, 1'b1, 1'b0);
      settle();
      if (k == LOSS_THRESH - 1) chk("loss_prev_locked", 32'(bus.locked), 1);
      if (k < LOSS_THRESH) repeat (9) drive(1'b1, 1'b0, 1'b0);
    end
    chk("loss_pulse", 32'(bus.sync_loss), 1);
    chk("loss_locked", 32'(bus.locked), 0);
    chk("loss_errpulse", 32'(bus.err_pulse), 1);
    chk("loss_count", 32'(bus.err_count), LOSS_THRESH);
    lock_check("relock_loss");

    // Constant streams never lock
    do_reset();
    repeat (1000) drive_raw(1'b1, 1'b0, 1'b0);
    settle();
    chk("zero_locked", 32'(bus.locked), 0);
    chk("zero_count", 32'(bus.err_count), 0);
    do_reset();
    repeat (1000) drive_raw(1'b1, 1'b1, 1'b0);
    settle();
    chk("ones_locked", 32'(bus.locked), 0);
    chk("ones_count", 32'(bus.err_count), 0);

    // Alternating bit_valid
    do_reset();
    for (int i = 1; i <= LOCK_LAT; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      if (i == LOCK_LAT - 1) begin settle(); chk("alt_prelock", 32'(bus.locked), 0); end
      if (i < LOCK_LAT) drive(1'b0, 1'b0, 1'b0);
    end
    settle();
    chk("alt_lock", 32'(bus.locked), 1);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    settle();
    chk("clear_with_err", 32'(bus.err_count), 1);
    drive(1'b1, 1'b0, 1'b1);

    // Reset mid-lock with err_count=5
    repeat (5) begin
      drive(1'b1, 1'b1, 1'b0);
      repeat (3) drive(1'b1, 1'b0, 1'b0);
    end
    settle();
    chk("five_count", 32'(bus.err_count), 5);
    do_reset();
    settle();
    chk("mid_rst_locked", 32'(bus.locked), 0);
    chk("mid_rst_count", 32'(bus.err_count), 0);
    chk("mid_rst_pulse", 32'(bus.err_pulse), 0);
    chk("mid_rst_loss", 32'(bus.sync_loss), 0);
    lock_check("relock_rst");

    // Randomised traffic with varying error density
    for (int seg = 0; seg < 8; seg++) begin
      rate = $urandom_range(0, 3);
      repeat (500) begin
        bit v, f, c;
        v = ($urandom_range(0, 3) != 0);
        c = ($urandom_range(0, 255) == 0);
        case (rate)
          0: f = 1'b0;
          1: f = ($urandom_range(0, 199) == 0);
          2: f = ($urandom_range(0, 29) == 0);
          default: f = ($urandom_range(0, 7) == 0);
        endcase
        drive(v, f, c);
      end
    end

    settle();
    settle();
    chk("sb_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/prbs_checker.md
# prbs_checker

Serial PRBS checker that sits directly downstream of the team's 32-bit Fibonacci LFSR generator. It consumes the newly generated bit each cycle (generator bit 0, polynomial taps 32,30,26,25) and self-synchronises to the stream. Once locked, it runs a free-running local reference, counts bit errors, and declares loss of sync when the error density is too high. Used for link and loopback BER tests.

## Interface
- LOCK_COUNT, 64: consecutive correct predictions required to declare lock.
- WINDOW, 256: valid bits per error-density window in LOCKED.
- LOSS_THRESH, 16: errors within one window that force loss of sync.
- CNT_W, 16: width of err_count.

- clk  input  1  clock, all logic on the rising edge.
- rst_n  input  1  reset; one clock; synchronous, active-low.
- bit_in  input  1  received stream bit.
- bit_valid  input  1  bit_in is sampled only when high.
- clear_count  input  1  synchronous clear of err_count.
- locked  output  1  high while in LOCKED.
- err_pulse  output  1  one-cycle pulse per counted error.
- sync_loss  output  1  one-cycle pulse on LOCKED->SEED transition.
- err_count  output  CNT_W  saturating error count.

## Operation
- Stream law: s[n] = s[n-32] ^ s[n-30] ^ s[n-26] ^ s[n-25]. The 32-bit history h holds h[0] = newest bit and h[k] = bit k+1 valid samples ago. prediction p = h[31]^h[29]^h[25]^h[24].
- Every register changes only on edges where bit_valid=1, except for reset and clear_count.
- States: SEED, VERIFY, LOCKED.
- SEED:
  - Shift bit_in into h and increment the fill count (0..31).
  - After the 32nd bit: if h (including this bit) is all-zero, restart the fill at 0. Otherwise go to VERIFY with the match count at 0.
- VERIFY:
  - Compare bit_in with p and shift bit_in into h.
  - On a match, increment the match count. When it reaches LOCK_COUNT, go to LOCKED and clear the window counters.
  - On a mismatch, go to SEED with the fill count at 0. No error is counted.
- LOCKED:
  - Shift p (not bit_in) into h, so the reference is free-running and one flipped bit yields exactly one error.
  - On a mismatch: err_pulse, err_count+1 (saturate at 2^CNT_W-1), and window error count +1.
  - The window bit count is incremented on each valid bit. When WINDOW bits have been seen, both window counters reset to 0.
  - If the window error count reaches LOSS_THRESH: go to SEED with the fill count at 0 and pulse sync_loss. err_count is retained.
- Errors are counted only in LOCKED.
- clear_count:
  - Sets err_count to 0 regardless of bit_valid.
  - If an error is counted in the same cycle, err_count becomes 1 (the error is not lost).
- The all-zero history is never accepted, so a constant-0 input never locks. A constant-1 input fails prediction and never locks.

## Timing
- Reset (rst_n=0 at an edge):
  - State becomes SEED; h, fill, match and window counters become 0.
  - locked=0, err_pulse=0, sync_loss=0, err_count=0.
  - Reset overrides all other inputs, including mid-lock.
- All outputs are registered. Effects appear after the edge that samples the causing bit.
- Lock latency from reset with a continuous valid, error-free stream: locked rises after the edge sampling valid bit 32+LOCK_COUNT (96 by default).
- err_pulse is high for exactly the cycle following the edge that sampled the bad bit. It is low otherwise, including when bit_valid=0.
- sync_loss and the falling edge of locked occur in the same cycle, following the edge that sampled the LOSS_THRESH-th window error. That error also produces err_pulse in the same cycle.
- Relock after sync_loss takes a further 32+LOCK_COUNT valid bits.
- Window boundary: an error on the WINDOW-th bit counts toward the closing window. The counters then reset.

## Test plan
- Reset, then drive generator bit 0 (seed 1) with bit_valid=1 every cycle → locked rises after 96 valid bits; err_count=0 and no err_pulse over 10000 cycles.
- After lock, invert a single bit → exactly one err_pulse, err_count=1, locked stays 1. Then assert clear_count → err_count=0 next cycle.
- After lock, invert 16 bits within one 256-bit window → 16 err_pulses, sync_loss pulse with locked=0 on the 16th, err_count=16; clean stream afterwards → locked after 96 more valid bits.
- Constant bit_in=0 for 1000 valid bits → locked never rises, err_count=0. Repeat with bit_in=1 → same result.
- bit_valid toggling 1,0,1,0 with an error-free stream → lock after 96 valid bits (192 cycles), no errors. clear_count on the same edge as an error → err_count=1.
- While locked with err_count=5, assert rst_n=0 for one edge → all outputs 0 next cycle; the stream relocks after 96 valid bits.
